// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register-file write path.
package regfile_pkg;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  // Low bit of element idx inside a packed bus of equal-width slices.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/dflipflop_en.sv
// Enable-gated D flip-flop register, one entry of the register array.
module dflipflop_en #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible index at or after ptr, wrapping.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   win,
  output logic            valid
);

  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    valid = 1'b0;
    // Walk offsets from farthest to nearest so the nearest eligible index is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (elig[idx]) begin
        win   = PW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter and write sequencer for the shared register-file write port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREG-1:0]  reg_en,
  output logic [DW-1:0]    reg_d,
  output logic             err
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q,    ptr_d;
  logic [NREQ-1:0] gnt_q,    gnt_d;
  logic [NREG-1:0] reg_en_q, reg_en_d;
  logic [DW-1:0]   reg_d_q,  reg_d_d;
  logic            err_q,    err_d;

  logic [NREQ-1:0] elig;
  logic [PW-1:0]   win;
  logic            win_valid;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // A requester still seeing its grant is masked so a held request is not taken twice.
  assign elig = req & ~gnt_q;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr_q),
    .win   (win),
    .valid (win_valid)
  );

  always_comb begin
    win_addr = addr[slice_lo(int'(win), AW) +: AW];
    win_data = wdata[slice_lo(int'(win), DW) +: DW];
  end

  always_comb begin
    ptr_d    = ptr_q;
    gnt_d    = '0;
    reg_en_d = '0;
    reg_d_d  = reg_d_q;
    err_d    = 1'b0;
    if (win_valid) begin
      gnt_d[win] = 1'b1;
      ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      reg_d_d    = win_data;
      err_d      = (int'(win_addr) >= NREG);
      // Out-of-range addresses match no register, so they leave reg_en all-zero.
      for (int r = 0; r < NREG; r++) begin
        if ((win_addr == AW'(r)) && !(ZERO_R0 && (r == 0))) reg_en_d[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      reg_en_q <= '0;
      reg_d_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      reg_en_q <= reg_en_d;
      reg_d_q  <= reg_d_d;
      err_q    <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign reg_en = reg_en_q;
  assign reg_d  = reg_d_q;
  assign err    = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table vectors through a scoreboard plus hand-written corner sequences.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 4;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NR20 = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic arr_rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREG-1:0]    reg_en;
  logic [DW-1:0]      reg_d;
  logic               err;

  logic [NREQ-1:0]    req20;
  logic [NREQ*AW-1:0] addr20;
  logic [NREQ*DW-1:0] wdata20;
  logic [NREQ-1:0]    gnt20;
  logic [NR20-1:0]    en20;
  logic [DW-1:0]      regd20;
  logic               err20;

  regfile_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW), .ZERO_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .err(err)
  );

  regfile_write_arbiter #(.NREQ(NREQ), .NREG(NR20), .AW(AW), .DW(DW), .ZERO_R0(1'b1)) dut20 (
    .clk(clk), .rst_n(rst_n), .req(req20), .addr(addr20), .wdata(wdata20),
    .gnt(gnt20), .reg_en(en20), .reg_d(regd20), .err(err20)
  );

  // The array has its own reset so a DUT reset alone cannot hide a lost write.
  logic [DW-1:0] rq [NREG];
  for (genvar g = 0; g < NREG; g++) begin : g_arr
    dflipflop_en #(.W(DW)) u_ff (
      .clk(clk), .rst_n(arr_rst_n), .en(reg_en[g]), .d(reg_d), .q(rq[g])
    );
  end

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREG-1:0]    en;
    logic               err;
    int                 chk_reg;
    logic [DW-1:0]      chk_val;
  } vec_t;

  typedef struct {
    int              id;
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] en;
    logic            err;
    int              chk_reg;
    logic [DW-1:0]   chk_val;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [NREQ*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NREQ*DW-1:0] pw(input int d0, input int d1, input int d2, input int d3);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d,
                     input logic [NREQ-1:0] g, input int en_idx, input logic e,
                     input int creg, input logic [DW-1:0] cval);
    vec_t v;
    v.req = r; v.addr = a; v.wdata = d; v.gnt = g;
    v.en = '0;
    if (en_idx >= 0) v.en[en_idx] = 1'b1;
    v.err = e; v.chk_reg = creg; v.chk_val = cval;
    vecs.push_back(v);
  endtask

  task automatic step20(input logic [NREQ-1:0] r, input int a0, input int d0,
                        input logic [NREQ-1:0] g, input int en_idx, input logic e, input string name);
    logic [NR20-1:0] en_exp;
    en_exp = '0;
    if (en_idx >= 0) en_exp[en_idx] = 1'b1;
    @(negedge clk);
    req20 = r; addr20 = pa(a0, 0, 0, 0); wdata20 = pw(d0, 0, 0, 0);
    @(posedge clk); #1;
    chk({name, "_gnt"}, 64'(gnt20), 64'(g));
    chk({name, "_en"},  64'(en20),  64'(en_exp));
    chk({name, "_err"}, 64'(err20), 64'(e));
  endtask

  localparam logic [NREQ*AW-1:0] ROT_A = {AW'(8), AW'(6), AW'(5), AW'(4)};
  localparam logic [NREQ*DW-1:0] ROT_D = {DW'(32'hA3), DW'(32'hA2), DW'(32'hA1), DW'(32'hA0)};

  initial begin
    exp_t e;
    rst_n = 1'b0; arr_rst_n = 1'b0;
    req = '0; addr = '0; wdata = '0;
    req20 = '0; addr20 = '0; wdata20 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; arr_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt",   64'(gnt),    64'd0);
    chk("rst_en",    64'(reg_en), 64'd0);
    chk("rst_err",   64'(err),    64'd0);
    chk("rst_regd",  64'(reg_d),  64'd0);

    // single write
    add(4'b0001, pa(3,0,0,0), pw(32'hDEADBEEF,0,0,0), 4'b0001, 3, 1'b0, -1, '0);
    add(4'b0000, '0, '0, 4'b0000, -1, 1'b0, 3, 32'hDEADBEEF);
    // rotation from ptr=1 with all four held
    add(4'b1111, ROT_A, ROT_D, 4'b0010, 5, 1'b0, -1, '0);
    add(4'b1111, ROT_A, ROT_D, 4'b0100, 6, 1'b0, 5, 32'hA1);
    add(4'b1111, ROT_A, ROT_D, 4'b1000, 8, 1'b0, 6, 32'hA2);
    add(4'b1111, ROT_A, ROT_D, 4'b0001, 4, 1'b0, 8, 32'hA3);
    add(4'b1111, ROT_A, ROT_D, 4'b0010, 5, 1'b0, 4, 32'hA0);
    add(4'b0000, '0, '0, 4'b0000, -1, 1'b0, 5, 32'hA1);
    // single requester held: every other cycle
    add(4'b0100, pa(0,0,9,0), pw(0,0,32'h99,0), 4'b0100, 9, 1'b0, -1, '0);
    add(4'b0100, pa(0,0,9,0), pw(0,0,32'h99,0), 4'b0000, -1, 1'b0, 9, 32'h99);
    add(4'b0100, pa(0,0,9,0), pw(0,0,32'h99,0), 4'b0100, 9, 1'b0, -1, '0);
    add(4'b0000, '0, '0, 4'b0000, -1, 1'b0, -1, '0);
    // register 0 discarded; ptr=3 wraps to requester 0
    add(4'b0001, pa(0,0,0,0), pw(32'h55,0,0,0), 4'b0001, -1, 1'b0, -1, '0);
    add(4'b0000, '0, '0, 4'b0000, -1, 1'b0, 0, 32'h0);
    // top register in range
    add(4'b1000, pa(0,0,0,31), pw(0,0,0,32'h31), 4'b1000, 31, 1'b0, -1, '0);
    add(4'b0000, '0, '0, 4'b0000, -1, 1'b0, 31, 32'h31);
    // collision on register 7, ptr set to 1 first
    add(4'b0001, pa(10,0,0,0), pw(32'h10,0,0,0), 4'b0001, 10, 1'b0, -1, '0);
    add(4'b0110, pa(0,7,7,0), pw(0,32'h11,32'h22,0), 4'b0010, 7, 1'b0, 10, 32'h10);
    add(4'b0100, pa(0,7,7,0), pw(0,32'h11,32'h22,0), 4'b0100, 7, 1'b0, 7, 32'h11);
    add(4'b0000, '0, '0, 4'b0000, -1, 1'b0, 7, 32'h22);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req = vecs[i].req; addr = vecs[i].addr; wdata = vecs[i].wdata;
      e.id = i; e.gnt = vecs[i].gnt; e.en = vecs[i].en; e.err = vecs[i].err;
      e.chk_reg = vecs[i].chk_reg; e.chk_val = vecs[i].chk_val;
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_gnt", e.id), 64'(gnt),    64'(e.gnt));
        chk($sformatf("v%0d_en",  e.id), 64'(reg_en), 64'(e.en));
        chk($sformatf("v%0d_err", e.id), 64'(err),    64'(e.err));
        if (e.chk_reg >= 0)
          chk($sformatf("v%0d_reg%0d", e.id, e.chk_reg), 64'(rq[e.chk_reg]), 64'(e.chk_val));
      end
    end

    // NREG=20 instance: range boundary and error pulse
    step20(4'b0001, 25, 32'h25, 4'b0001, -1, 1'b1, "oor25");
    step20(4'b0000, 0,  0,      4'b0000, -1, 1'b0, "oor_idle");
    step20(4'b0001, 19, 32'h19, 4'b0001, 19, 1'b0, "in19");
    chk("in19_regd", 64'(regd20), 64'h19);
    step20(4'b0001, 20, 32'h20, 4'b0000, -1, 1'b0, "mask20");
    step20(4'b0001, 20, 32'h20, 4'b0001, -1, 1'b1, "oor20");
    step20(4'b0000, 0,  0,      4'b0000, -1, 1'b0, "oor20_idle");

    // asynchronous reset while reg_en=0x4
    @(negedge clk);
    req = 4'b0001; addr = pa(2,0,0,0); wdata = pw(32'h77,0,0,0);
    @(posedge clk); #1;
    chk("pre_rst_en", 64'(reg_en), 64'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt",  64'(gnt),    64'd0);
    chk("async_en",   64'(reg_en), 64'd0);
    chk("async_err",  64'(err),    64'd0);
    chk("async_regd", 64'(reg_d),  64'd0);
    @(negedge clk);
    req = 4'b1001; addr = pa(12,0,0,13); wdata = pw(32'hC0,0,0,32'hC3);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_gnt", 64'(gnt),    64'b0001);
    chk("post_rst_en",  64'(reg_en), 64'h1000);
    chk("reg2_lost",    64'(rq[2]),  64'd0);
    @(negedge clk);
    req = '0;
    @(posedge clk); #1;
    chk("reg12", 64'(rq[12]), 64'hC0);
    chk("reg2_still", 64'(rq[2]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
